// File: rtl/ram_dma_multi_ci.sv
// Custom-instruction scratchpad RAM with a multi-channel burst DMA master.
// Define RAMDMA_ROUND_ROBIN_EN for round-robin channel arbitration; fixed priority otherwise.
module ram_dma_multi_ci #(
  parameter logic [7:0] customId       = 8'd15,
  parameter int         NR_OF_CHANNELS = 2,
  parameter int         RAM_ADDR_BITS  = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic        requestTransaction,
  input  logic        transactionGranted,
  input  logic [31:0] addressDataIn,
  input  logic        endTransactionIn,
  input  logic        dataValidIn,
  input  logic        busErrorIn,
  input  logic        busyIn,
  output logic [31:0] addressDataOut,
  output logic [3:0]  byteEnablesOut,
  output logic [7:0]  burstSizeOut,
  output logic        readNotWriteOut,
  output logic        beginTransactionOut,
  output logic        endTransactionOut,
  output logic        dataValidOut
);
  localparam int RAM_WORDS = 1 << RAM_ADDR_BITS;
  typedef enum logic [2:0] {S_IDLE, S_REQUEST, S_INIT, S_READ, S_WRITE, S_END} state_t;

  logic [31:0]              ram [RAM_WORDS];
  logic [31:0]              bus_addr [4];
  logic [RAM_ADDR_BITS-1:0] ram_addr [4];
  logic [9:0]               remaining [4];
  logic [7:0]               burst [4];
  logic [3:0]               busy, error, to_ram;

  state_t                   state, next_state;
  logic [1:0]               cur_ch, pick_ch;
  logic [9:0]               beats, beat_cnt, init_beats, burst_beats, beats_m1;
  logic [31:0]              rd_data;
  logic                     accept, ch_ok, cpu_wr, cfg_wr, cpu_ram_we, dma_we, abort;
  logic [2:0]               sel;
  logic [1:0]               ch;
  logic [RAM_ADDR_BITS-1:0] cpu_addr;
  logic                     unused_bits;
`ifdef RAMDMA_ROUND_ROBIN_EN
  logic [1:0]               last_ch, rr_idx;
`endif

  assign accept      = start && (ciN == customId);
  assign sel         = valueA[12:10];
  assign ch          = valueA[14:13];
  assign cpu_addr    = valueA[RAM_ADDR_BITS-1:0];
  assign ch_ok       = ({30'd0, ch} < 32'(NR_OF_CHANNELS));
  assign cpu_wr      = accept && valueA[9] && ch_ok;
  assign cfg_wr      = cpu_wr && (sel >= 3'd1) && (sel <= 3'd5) && !busy[ch];
  assign cpu_ram_we  = cpu_wr && (sel == 3'd0);
  assign abort       = busErrorIn && (state != S_IDLE);
  assign dma_we      = (state == S_READ) && dataValidIn && !busErrorIn;
  assign burst_beats = {2'd0, burst[cur_ch]} + 10'd1;
  assign init_beats  = (burst_beats < remaining[cur_ch]) ? burst_beats : remaining[cur_ch];
  assign beats_m1    = init_beats - 10'd1;
  assign unused_bits = &{1'b0, valueA[31:15], beats_m1[9:8]};

  // CPU read-back multiplexer
  always_comb begin
    rd_data = 32'd0;
    if (ch_ok) begin
      case (sel)
        3'd0:    rd_data = ram[cpu_addr];
        3'd1:    rd_data = bus_addr[ch];
        3'd2:    rd_data = 32'(ram_addr[ch]);
        3'd3:    rd_data = {22'd0, remaining[ch]};
        3'd4:    rd_data = {24'd0, burst[ch]};
        3'd5:    rd_data = {30'd0, error[ch], busy[ch]};
        3'd6:    rd_data = {28'd0, busy};
        default: rd_data = 32'd0;
      endcase
    end else begin
      rd_data = 32'd0;
    end
  end

  // Channel arbitration among pending (busy) channels
  always_comb begin
    pick_ch = 2'd0;
`ifdef RAMDMA_ROUND_ROBIN_EN
    rr_idx = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      rr_idx = last_ch + 2'(i);
      if (busy[rr_idx]) pick_ch = rr_idx;
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (busy[i]) pick_ch = 2'(i);
    end
`endif
  end

`ifdef RAMDMA_ROUND_ROBIN_EN
  // Remember the last served channel so the search starts just after it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_ch <= 2'd3;
    else if (state == S_INIT) last_ch <= cur_ch;
  end
`endif

  // Master FSM next state and bus output decode
  always_comb begin
    next_state          = state;
    requestTransaction  = 1'b0;
    addressDataOut      = 32'd0;
    byteEnablesOut      = 4'd0;
    burstSizeOut        = 8'd0;
    readNotWriteOut     = 1'b0;
    beginTransactionOut = 1'b0;
    endTransactionOut   = 1'b0;
    dataValidOut        = 1'b0;
    case (state)
      S_IDLE: begin
        if (|busy) next_state = S_REQUEST;
        else next_state = S_IDLE;
      end
      S_REQUEST: begin
        requestTransaction = 1'b1;
        if (busErrorIn) next_state = S_IDLE;
        else if (transactionGranted) next_state = S_INIT;
        else next_state = S_REQUEST;
      end
      S_INIT: begin
        beginTransactionOut = 1'b1;
        addressDataOut      = bus_addr[cur_ch];
        burstSizeOut        = beats_m1[7:0];
        readNotWriteOut     = to_ram[cur_ch];
        byteEnablesOut      = 4'hF;
        if (busErrorIn) next_state = S_IDLE;
        else if (to_ram[cur_ch]) next_state = S_READ;
        else next_state = S_WRITE;
      end
      S_READ: begin
        if (busErrorIn) next_state = S_IDLE;
        else if (endTransactionIn) next_state = S_END;
        else next_state = S_READ;
      end
      S_WRITE: begin
        dataValidOut   = 1'b1;
        addressDataOut = ram[ram_addr[cur_ch]];
        if (busErrorIn) next_state = S_IDLE;
        else if (!busyIn && (beat_cnt == beats - 10'd1)) next_state = S_END;
        else next_state = S_WRITE;
      end
      S_END: begin
        endTransactionOut = !to_ram[cur_ch];
        if (busErrorIn) next_state = S_IDLE;
        else if (remaining[cur_ch] > beats) next_state = S_REQUEST;
        else next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // FSM state, selected channel and per-burst beat bookkeeping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cur_ch   <= 2'd0;
      beats    <= 10'd0;
      beat_cnt <= 10'd0;
    end else begin
      state <= next_state;
      if ((next_state == S_REQUEST) && (state != S_REQUEST)) cur_ch <= pick_ch;
      if (state == S_INIT) begin
        beats    <= init_beats;
        beat_cnt <= 10'd0;
      end else if ((state == S_WRITE) && !busyIn) begin
        beat_cnt <= beat_cnt + 10'd1;
      end
    end
  end

  // Channel registers: CPU configuration plus DMA progress updates
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        bus_addr[i]  <= 32'd0;
        ram_addr[i]  <= '0;
        remaining[i] <= 10'd0;
        burst[i]     <= 8'd0;
      end
      busy   <= 4'd0;
      error  <= 4'd0;
      to_ram <= 4'd0;
    end else begin
      if (cfg_wr) begin
        case (sel)
          3'd1: bus_addr[ch]  <= valueB;
          3'd2: ram_addr[ch]  <= valueB[RAM_ADDR_BITS-1:0];
          3'd3: remaining[ch] <= valueB[9:0];
          3'd4: burst[ch]     <= valueB[7:0];
          3'd5: begin
            if ((valueB == 32'd1) || (valueB == 32'd2)) begin
              error[ch]  <= 1'b0;
              to_ram[ch] <= (valueB == 32'd1);
              busy[ch]   <= (remaining[ch] != 10'd0);
            end
          end
          default: ;
        endcase
      end
      if (abort) begin
        busy[cur_ch]  <= 1'b0;
        error[cur_ch] <= 1'b1;
      end else begin
        case (state)
          S_READ:  if (dataValidIn) ram_addr[cur_ch] <= ram_addr[cur_ch] + RAM_ADDR_BITS'(1);
          S_WRITE: if (!busyIn) ram_addr[cur_ch] <= ram_addr[cur_ch] + RAM_ADDR_BITS'(1);
          S_END: begin
            bus_addr[cur_ch]  <= bus_addr[cur_ch] + {20'd0, beats, 2'b00};
            remaining[cur_ch] <= remaining[cur_ch] - beats;
            if (remaining[cur_ch] <= beats) busy[cur_ch] <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Scratchpad; the CPU write is issued last so it wins an address collision
  always_ff @(posedge clock) begin
    if (dma_we) ram[ram_addr[cur_ch]] <= addressDataIn;
    if (cpu_ram_we) ram[cpu_addr] <= valueB;
  end

  // Custom-instruction handshake: one-cycle done with result, zero otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      done   <= accept;
      result <= accept ? rd_data : 32'd0;
    end
  end
endmodule
